inst_fetch: RTL

//  Instruction fetch stage; sits directly upstream of inst_memory and feeds the decode stage.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/inst_fetch.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM encoding (RUN = fetching, EXC_WAIT = halted after exception)
//   DEF_NOP_INST  : default instruction word used for bubbles and squashed slots
//   DEF_RESET_VEC : default PC loaded on reset
package fetch_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        EXC_WAIT = 1'b1
    } fetch_state_t;

    localparam logic [15:0] DEF_NOP_INST  = 16'h0000;
    localparam logic [15:0] DEF_RESET_VEC = 16'h0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds {inst, pc, valid, exc} for the decode stage.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears to bubble)
//   load              : capture {d_inst, d_pc, valid=1, d_exc}
//   bubble            : clear to {NOP_INST, 0, valid=0, exc=0}
//   d_inst/d_pc/d_exc : slot contents to load
//   inst/pc/valid/exc : registered slot
// Neither load nor bubble means hold. bubble has priority over load.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [DATA_W-1:0] d_inst,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic              d_exc,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic              valid,
    output logic              exc
);

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            inst  <= NOP_INST;
            pc    <= '0;
            valid <= 1'b0;
            exc   <= 1'b0;
        end else if (load) begin
            inst  <= d_inst;
            pc    <= d_pc;
            valid <= 1'b1;
            exc   <= d_exc;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, addresses inst_memory combinationally
// and captures the returned word into the IF/ID register for decode.
// Optional macro: IFETCH_PERF_EN adds saturating perf_fetch_cnt / perf_stall_cnt.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mem_addr            : address to inst_memory (= pc)
//   mem_data, mem_exc   : same-cycle word and exception from inst_memory
//   stall               : downstream hold request
//   redirect, redirect_pc : taken branch/jump and its target
//   if_inst/if_pc/if_valid/if_exc : IF/ID slot to decode
//   dbg_state           : current fetch FSM state
//   perf_fetch_cnt, perf_stall_cnt : (IFETCH_PERF_EN only) event counters
// Handshake: if_valid qualifies the IF/ID slot; stall is back-pressure from
// decode. While stall=1 (and no redirect) the slot and PC hold, so decode
// consumes exactly one slot per edge with stall=0. Redirect ignores stall.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [DATA_W-1:0] NOP_INST  = DEF_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_exc,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic              if_valid,
    output logic              if_exc,
    output fetch_state_t      dbg_state
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    logic [ADDR_W-1:0] pc;
    fetch_state_t      state;

    logic              slot_load;
    logic              slot_bubble;
    logic [DATA_W-1:0] slot_inst;
    logic              slot_exc;

    assign mem_addr  = pc;
    assign dbg_state = state;

    // Slot control, priority redirect > stall > normal.
    // An exception slot carries NOP_INST rather than the faulting word.
    always_comb begin
        slot_load   = 1'b0;
        slot_bubble = 1'b0;
        slot_inst   = mem_data;
        slot_exc    = 1'b0;
        if (redirect) begin
            slot_bubble = 1'b1;
        end else if (!stall) begin
            if (state == RUN) begin
                slot_load = 1'b1;
                slot_exc  = mem_exc;
                if (mem_exc) slot_inst = NOP_INST;
            end else begin
                slot_bubble = 1'b1;
            end
        end
    end

    // PC register, next-PC selection and fetch FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_VEC;
            state <= RUN;
        end else if (redirect) begin
            pc    <= redirect_pc;
            state <= RUN;
        end else if (!stall && state == RUN) begin
            if (mem_exc) begin
                // Keep pc at the faulting address until software redirects.
                state <= EXC_WAIT;
            end else begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .load   (slot_load),
        .bubble (slot_bubble),
        .d_inst (slot_inst),
        .d_pc   (pc),
        .d_exc  (slot_exc),
        .inst   (if_inst),
        .pc     (if_pc),
        .valid  (if_valid),
        .exc    (if_exc)
    );

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (slot_load && !slot_exc && perf_fetch_cnt != 32'hFFFF_FFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && !redirect && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
